// File: rtl/a_usb_rx_pkg.sv
// Shared types and defaults for the USB FIFO byte-to-word receive path.
package a_usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_LOW,
    RD_GAP
  } rx_state_e;

  localparam int RD_PULSE_CYCLES_DEF = 4;
  localparam int RD_GAP_CYCLES_DEF   = 3;
  localparam int TIMEOUT_CYCLES_DEF  = 50000;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/a_sync_2ff.sv
// One-bit two-flop synchronizer with asynchronous active-high reset to RST_VAL.
module a_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/a_usb_word_assembler.sv
// Drains an FT245-style FIFO and pairs bytes MSB-first into 16-bit words.
// Optional orphan-byte timeout is compiled in with `define USB_RX_TIMEOUT_EN.
module a_usb_word_assembler
  import a_usb_rx_pkg::*;
#(
  parameter int RD_PULSE_CYCLES = RD_PULSE_CYCLES_DEF,
  parameter int RD_GAP_CYCLES   = RD_GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              usb_rxf_n_i,
  input  logic [BYTE_W-1:0] usb_data_i,
  output logic              usb_rd_n_o,
  input  logic              hold_i,
  output logic [WORD_W-1:0] data_o,
  output logic              dv_o,
  output logic              timeout_o,
  output logic [WORD_W-1:0] word_cnt_o
);

  localparam logic [7:0] PULSE_LAST = 8'(RD_PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(RD_GAP_CYCLES - 1);

  logic              w_rxf_s;
  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              r_rd_n;
  logic              w_rd_n_nxt;
  logic              w_capture;
  logic              w_expire;

  logic              r_phase;
  logic [BYTE_W-1:0] r_hi;
  logic [WORD_W-1:0] r_data;
  logic              r_dv;
  logic              r_timeout;
  logic [WORD_W-1:0] r_word_cnt;

  a_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rxf_sync (
    .i_clk (clk_ref),
    .i_rst (rst),
    .i_d   (usb_rxf_n_i),
    .o_q   (w_rxf_s)
  );

  // Read-strobe FSM: state, phase counter and the strobe itself are registered together
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_n  <= w_rd_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_n_nxt  = 1'b1;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxf_s && !hold_i) begin
          w_state_nxt = RD_LOW;
          w_cnt_nxt   = '0;
          w_rd_n_nxt  = 1'b0;
        end
      end
      RD_LOW: begin
        // Data is sampled on the same edge that releases the strobe
        if (r_cnt == PULSE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = RD_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_rd_n_nxt  = 1'b0;
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      RD_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef USB_RX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;

  // Counts only while a high byte is waiting; a capture always beats expiry
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (!r_phase || w_capture || (r_to_cnt == TO_LAST)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign w_expire = r_phase && !w_capture && (r_to_cnt == TO_LAST);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^16'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
`endif

  // Byte pairing and word output
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_phase    <= 1'b0;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_timeout  <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_dv      <= w_capture && r_phase;
      r_timeout <= w_expire;
      if (w_capture) begin
        r_phase <= ~r_phase;
        if (r_phase) begin
          r_data     <= {r_hi, usb_data_i};
          r_word_cnt <= r_word_cnt + 16'd1;
        end
      end else if (w_expire) begin
        r_phase <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (w_capture && !r_phase) begin
      r_hi <= usb_data_i;
    end
  end

  assign usb_rd_n_o = r_rd_n;
  assign data_o     = r_data;
  assign dv_o       = r_dv;
  assign timeout_o  = r_timeout;
  assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_a_usb_word_assembler.sv
// Directed bench for a_usb_word_assembler; timeout cases run when USB_RX_TIMEOUT_EN is defined.
module tb_a_usb_word_assembler;

  logic        clk_ref;
  logic        rst;
  logic        usb_rxf_n_i;
  logic [7:0]  usb_data_i;
  logic        usb_rd_n_o;
  logic        hold_i;
  logic [15:0] data_o;
  logic        dv_o;
  logic        timeout_o;
  logic [15:0] word_cnt_o;

  int errors = 0;
  int checks = 0;

  a_usb_word_assembler #(
    .RD_PULSE_CYCLES (4),
    .RD_GAP_CYCLES   (3),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clk_ref     (clk_ref),
    .rst         (rst),
    .usb_rxf_n_i (usb_rxf_n_i),
    .usb_data_i  (usb_data_i),
    .usb_rd_n_o  (usb_rd_n_o),
    .hold_i      (hold_i),
    .data_o      (data_o),
    .dv_o        (dv_o),
    .timeout_o   (timeout_o),
    .word_cnt_o  (word_cnt_o)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  // FIFO model: byte pops when the read strobe returns high
  logic [7:0] fmem [0:63];
  int wp = 0;
  int rp = 0;

  assign usb_rxf_n_i = (wp == rp);
  assign usb_data_i  = fmem[rp[5:0]];

  always @(posedge usb_rd_n_o) begin
    if (rp != wp) rp <= rp + 1;
  end

  int cyc = 0;
  always @(posedge clk_ref) cyc <= cyc + 1;

  int   pulses [$];
  int   gaps [$];
  int   words [$];
  int   word_cyc [$];
  int   to_pulses = 0;
  int   rd_starts = 0;
  int   lo_run = 0;
  int   hi_run = 0;
  logic prev_rd_n = 1'b1;
  logic seen_pulse = 1'b0;

  always @(negedge clk_ref) begin
    if (usb_rd_n_o == 1'b0) begin
      if (prev_rd_n) begin
        rd_starts <= rd_starts + 1;
        if (seen_pulse) gaps.push_back(hi_run);
      end
      lo_run <= lo_run + 1;
      hi_run <= 0;
    end else begin
      if (lo_run > 0) begin
        pulses.push_back(lo_run);
        seen_pulse <= 1'b1;
      end
      lo_run <= 0;
      hi_run <= hi_run + 1;
    end
    prev_rd_n <= usb_rd_n_o;
    if (dv_o) begin
      words.push_back(int'(data_o));
      word_cyc.push_back(cyc);
    end
    if (timeout_o) to_pulses <= to_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[5:0]] = b;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    @(negedge clk_ref);
    rst = 1'b1;
    repeat (3) @(negedge clk_ref);
    wp = rp;
    rst = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget);
    int n;
    n = 0;
    while (words.size() < target && n < budget) begin
      @(negedge clk_ref);
      #1;
      n++;
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (rd_starts < target && n < budget) begin
      @(negedge clk_ref);
      #1;
      n++;
    end
  endtask

  initial begin
    int wb;
    int pb;
    int gb;
    int sb;
    int tb0;
    rst    = 1'b1;
    hold_i = 1'b0;

    repeat (2) @(negedge clk_ref);
    check("rst_rd_n", usb_rd_n_o, 1);
    check("rst_data", data_o, 16'h0000);
    check("rst_dv", dv_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_word_cnt", word_cnt_o, 16'h0000);
    rst = 1'b0;

    // Single word
    wb = words.size(); pb = pulses.size(); gb = gaps.size();
    push(8'h12); push(8'h34);
    wait_words(wb + 1, 100);
    repeat (10) @(negedge clk_ref);
    check("t1_dv_count", words.size() - wb, 1);
    if (words.size() > wb) check("t1_data", words[wb], 32'h1234);
    check("t1_word_cnt", word_cnt_o, 16'h0001);
    check("t1_pulses", pulses.size() - pb, 2);
    if (pulses.size() >= pb + 2) begin
      check("t1_pulse0_w", pulses[pb], 4);
      check("t1_pulse1_w", pulses[pb + 1], 4);
    end
    if (gaps.size() > gb) check("t1_gap_ge3", gaps[gb] >= 3, 1);

    // Back-to-back burst
    do_reset();
    wb = words.size();
    for (int i = 0; i < 8; i++) push(8'(i));
    wait_words(wb + 4, 200);
    check("t2_dv_count", words.size() - wb, 4);
    if (words.size() >= wb + 4) begin
      check("t2_w0", words[wb],     32'h0001);
      check("t2_w1", words[wb + 1], 32'h0203);
      check("t2_w2", words[wb + 2], 32'h0405);
      check("t2_w3", words[wb + 3], 32'h0607);
      for (int i = 0; i < 3; i++)
        check("t2_spacing", word_cyc[wb + i + 1] - word_cyc[wb + i], 16);
    end
    check("t2_word_cnt", word_cnt_o, 16'h0004);

    // Stall
    do_reset();
    hold_i = 1'b1;
    sb = rd_starts; wb = words.size();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (30) @(negedge clk_ref);
    check("t3_held_starts", rd_starts - sb, 0);
    hold_i = 1'b0;
    wait_starts(sb + 1, 20);
    hold_i = 1'b1;
    pb = pulses.size();
    repeat (40) @(negedge clk_ref);
    check("t3_one_start", rd_starts - sb, 1);
    if (pulses.size() > pb) check("t3_pulse_w", pulses[pb], 4);
    else check("t3_pulse_done", pulses.size() - pb, 1);
    check("t3_rd_n_idle", usb_rd_n_o, 1);
    check("t3_no_word", words.size() - wb, 0);
    hold_i = 1'b0;
    wait_words(wb + 2, 100);
    check("t3_dv_count", words.size() - wb, 2);
    if (words.size() >= wb + 2) begin
      check("t3_w0", words[wb],     32'hA1A2);
      check("t3_w1", words[wb + 1], 32'hA3A4);
    end
    check("t3_word_cnt", word_cnt_o, 16'h0002);

    // Reset during the low-byte read
    repeat (5) @(negedge clk_ref);
    sb = rd_starts;
    push(8'hDE); push(8'hAD);
    wait_starts(sb + 2, 40);
    check("t4_low_byte_reading", usb_rd_n_o, 0);
    rst = 1'b1;
    #1;
    check("t4_rd_n", usb_rd_n_o, 1);
    check("t4_data", data_o, 16'h0000);
    check("t4_dv", dv_o, 0);
    check("t4_timeout", timeout_o, 0);
    check("t4_word_cnt", word_cnt_o, 16'h0000);
    repeat (3) @(negedge clk_ref);
    wp = rp;
    rst = 1'b0;
    wb = words.size();
    push(8'hBE); push(8'hEF);
    wait_words(wb + 1, 100);
    check("t4_dv_count", words.size() - wb, 1);
    check("t4_data_after", data_o, 16'hBEEF);
    check("t4_word_cnt_after", word_cnt_o, 16'h0001);

    // Counter wrap
    repeat (10) @(negedge clk_ref);
    force dut.r_word_cnt = 16'hFFFF;
    @(negedge clk_ref);
    release dut.r_word_cnt;
    @(negedge clk_ref);
    check("t5_preload", word_cnt_o, 16'hFFFF);
    wb = words.size();
    push(8'h01); push(8'h02);
    wait_words(wb + 1, 100);
    check("t5_data", data_o, 16'h0102);
    check("t5_word_cnt_wrap", word_cnt_o, 16'h0000);

`ifdef USB_RX_TIMEOUT_EN
    // Orphan high byte
    do_reset();
    wb = words.size(); tb0 = to_pulses;
    push(8'hAA);
    repeat (50) @(negedge clk_ref);
    check("t6_timeout_pulses", to_pulses - tb0, 1);
    check("t6_no_dv", words.size() - wb, 0);
    push(8'h55); push(8'h66);
    wait_words(wb + 1, 100);
    check("t6_realigned", data_o, 16'h5566);

    // Low byte captured exactly on the expiry edge
    repeat (10) @(negedge clk_ref);
    wb = words.size(); tb0 = to_pulses; pb = pulses.size();
    push(8'h77);
    for (int n = 0; n < 40 && pulses.size() <= pb; n++) begin
      @(negedge clk_ref);
      #1;
    end
    repeat (13) @(posedge clk_ref);
    #1;
    push(8'h88);
    wait_words(wb + 1, 100);
    repeat (30) @(negedge clk_ref);
    check("t7_dv_count", words.size() - wb, 1);
    check("t7_data", data_o, 16'h7788);
    check("t7_no_timeout", to_pulses - tb0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
